// File: rtl/mips_pkg.sv
// Shared fetch-stage types: queue entry layout, fetch FSM states and reset PC.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, word} queue with push/pop/flush and a registered head.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues one word request at a time and
// queues returned words for decode; redirect flushes and restarts fetch.
module instr_fetch_buffer
    import mips_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;

    logic          push;
    logic          pop;
    logic          flush;
    logic          ack_ok;
    logic [CW-1:0] count;
    logic [31:0]   target;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Request is a pure decode of registered state; reset gates it at once.
    assign mem_req  = rst & ((state_q == FETCH_DRAIN) | (count < CW'(DEPTH)));
    assign mem_addr = fetch_pc_q;
    assign ack_ok   = mem_ack & mem_req;
    assign target   = word_align(redirect_pc);

    assign instr_valid = (count != '0);
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign pop         = instr_valid & instr_ready;

    assign push_entry.pc   = fetch_pc_q;
    assign push_entry.word = mem_rdata;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        push         = 1'b0;
        flush        = 1'b0;
        if (redirect) begin
            flush = 1'b1;
            unique case (state_q)
                FETCH_RUN: begin
                    if (mem_req && !mem_ack) begin
                        pending_pc_d = target;
                        state_d      = FETCH_DRAIN;
                    end else begin
                        fetch_pc_d = target;
                    end
                end
                FETCH_DRAIN: begin
                    if (ack_ok) begin
                        fetch_pc_d = target;
                        state_d    = FETCH_RUN;
                    end else begin
                        pending_pc_d = target;
                    end
                end
            endcase
        end else begin
            unique case (state_q)
                FETCH_RUN: begin
                    if (ack_ok) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + XLEN'(4);
                    end
                end
                FETCH_DRAIN: begin
                    // Stale word from before the redirect is dropped here.
                    if (ack_ok) begin
                        fetch_pc_d = pending_pc_q;
                        state_d    = FETCH_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH_RUN;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head       (head)
    );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a reference queue model.
module tb_instr_fetch_buffer;
    import mips_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    logic        mem_req_w, mem_ack_w;
    logic [31:0] mem_addr_w, mem_rdata_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic        instr_valid_w, instr_ready_w;
    logic [31:0] instr_w, instr_pc_w;

    fetch_entry_t sb[$];
    logic [31:0]  m_pc, m_pend;
    bit           m_drain;
    int           lat, wcnt;
    int           n_pass, n_total, n_fail;
    int           wrap_idx;
    logic [31:0]  wrap_exp [3];

    always #5 clk = ~clk;

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w),
        .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
        .redirect(redirect_w), .redirect_pc(redirect_pc_w),
        .instr_valid(instr_valid_w), .instr(instr_w),
        .instr_pc(instr_pc_w), .instr_ready(instr_ready_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc     = 32'h0;
        m_pend   = 32'h0;
        m_drain  = 1'b0;
        wcnt     = 0;
        wrap_idx = 0;
    endtask

    // One clock: drive inputs at negedge, check against model, advance.
    task automatic cycle(input bit rd = 1'b0, input logic [31:0] rpc = 32'h0);
        bit           exp_req, exp_valid, ack, req_now, ack_now;
        fetch_entry_t e;
        redirect    = rd;
        redirect_pc = rpc;
        mem_ack     = mem_req && (wcnt >= lat);
        mem_rdata   = mem_ack ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;
        mem_ack_w   = mem_req_w;
        mem_rdata_w = mem_addr_w ^ KEY;
        #1;
        exp_req   = m_drain || (sb.size() < DEPTH);
        exp_valid = (sb.size() != 0);
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) chk("mem_addr", mem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid && instr_ready) begin
            e = sb.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.word);
        end
        ack = mem_ack && exp_req;
        if (rd) begin
            sb.delete();
            if (m_drain) begin
                if (ack) begin
                    m_pc    = {rpc[31:2], 2'b00};
                    m_drain = 1'b0;
                end else begin
                    m_pend = {rpc[31:2], 2'b00};
                end
            end else if (exp_req && !mem_ack) begin
                m_pend  = {rpc[31:2], 2'b00};
                m_drain = 1'b1;
            end else begin
                m_pc = {rpc[31:2], 2'b00};
            end
        end else if (m_drain) begin
            if (ack) begin
                m_pc    = m_pend;
                m_drain = 1'b0;
            end
        end else if (ack) begin
            e.pc   = m_pc;
            e.word = m_pc ^ KEY;
            sb.push_back(e);
            m_pc = m_pc + 32'd4;
        end
        if (wrap_idx < 3 && instr_valid_w) begin
            chk("wrap_pc", instr_pc_w, wrap_exp[wrap_idx]);
            chk("wrap_word", instr_w, wrap_exp[wrap_idx] ^ KEY);
            wrap_idx++;
        end
        req_now = mem_req;
        ack_now = mem_ack;
        @(posedge clk);
        if (req_now && ack_now) wcnt = 0;
        else if (req_now) wcnt++;
        else wcnt = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a0;
        bit          found;
        n_pass = 0; n_total = 0; n_fail = 0;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        rst = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b1;
        mem_ack_w = 1'b0; mem_rdata_w = '0;
        redirect_w = 1'b0; redirect_pc_w = '0;
        instr_ready_w = 1'b1;
        lat = 0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_req_w", 32'(mem_req_w), 32'h0);

        // Zero-wait stream from reset.
        rst = 1'b1;
        repeat (12) cycle();

        // Backpressure: refetch from 0 with consumer stalled.
        instr_ready = 1'b0;
        cycle(1'b1, 32'h0);
        repeat (10) cycle();
        chk("full_req", 32'(mem_req), 32'h0);
        chk("full_valid", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1;
        cycle();
        chk("refill_req", 32'(mem_req), 32'h1);
        chk("refill_addr", mem_addr, 32'h10);
        repeat (8) cycle();

        // Redirect while the request to 0x8 is in flight.
        lat = 2;
        cycle(1'b1, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_req && mem_addr == 32'h8 && wcnt == 0) found = 1'b1;
            else cycle();
        end
        chk("reach_8", 32'(found), 32'h1);
        cycle();
        cycle(1'b1, 32'h100);
        chk("drain_req", 32'(mem_req), 32'h1);
        chk("drain_addr", mem_addr, 32'h8);
        chk("drain_valid", 32'(instr_valid), 32'h0);
        cycle();
        chk("post_drain_addr", mem_addr, 32'h100);
        repeat (12) cycle();

        // Redirect coinciding with the ack for 0xC.
        lat = 0;
        cycle(1'b1, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req && mem_addr == 32'hC) found = 1'b1;
            else cycle();
        end
        chk("reach_c", 32'(found), 32'h1);
        cycle(1'b1, 32'h202);
        chk("sc_req", 32'(mem_req), 32'h1);
        chk("sc_addr", mem_addr, 32'h200);
        chk("sc_valid", 32'(instr_valid), 32'h0);
        repeat (6) cycle();

        // Two redirects while draining; only the newest survives.
        lat = 4;
        a0 = mem_addr;
        cycle(1'b1, 32'h300);
        cycle(1'b1, 32'h400);
        chk("dbl_hold", mem_addr, a0);
        chk("dbl_valid", 32'(instr_valid), 32'h0);
        for (int i = 0; i < 40 && !instr_valid; i++) cycle();
        chk("dbl_first", instr_pc, 32'h400);
        repeat (4) cycle();

        // Asynchronous reset between edges.
        lat = 0;
        repeat (4) cycle();
        #2;
        rst = 1'b0;
        mem_ack = 1'b0;
        mem_ack_w = 1'b0;
        #1;
        chk("async_valid", 32'(instr_valid), 32'h0);
        chk("async_req", 32'(mem_req), 32'h0);
        chk("async_req_w", 32'(mem_req_w), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Fetch stage that sits directly upstream of the single-cycle datapath's instruction input. It owns the fetch PC, issues sequential word fetches to a variable-latency instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small FIFO. The decode side pops them with a valid/ready handshake. A branch/jump `redirect` flushes the buffer and restarts fetch at the new target.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `mem_req`  out  1  — fetch request; held until `mem_ack`.
- `mem_addr`  out  32  — word address of the request; stable while `mem_req`=1 and `mem_ack`=0.
- `mem_ack`  in  1  — request completes this cycle; `mem_rdata` is valid.
- `mem_rdata`  in  32  — fetched instruction word.
- `redirect`  in  1  — flush and restart fetch.
- `redirect_pc`  in  32  — new fetch target; bits[1:0] ignored (forced 0).
- `instr_valid`  out  1  — queue head is valid.
- `instr`  out  32  — head instruction word.
- `instr_pc`  out  32  — PC of head instruction.
- `instr_ready`  in  1  — consumer accepts head this cycle.

## Operation
- The queue is an array of {pc, word}, `count` from 0..DEPTH. Push occurs on an accepted `mem_ack` in RUN. Pop occurs on `instr_valid & instr_ready`. Push and pop in the same cycle are both allowed, and `count` is unchanged.
- `fetch_pc` is the address of the next or outstanding request. It advances by 4 on each accepted ack and wraps modulo 2^32 (0xFFFF_FFFC → 0).
- FSM states:
  - RUN: `mem_req` = (`count` < DEPTH). `mem_addr` = `fetch_pc`.
  - DRAIN: a request is outstanding while a redirect is pending. `mem_req`=1, and `mem_addr` holds the old address. On `mem_ack`, the returned data is discarded, `fetch_pc` ← `pending_pc`, and the FSM goes to RUN.
- Redirect handling. `redirect` has priority over everything else. It always sets `count` ← 0, and any pop accepted in that cycle still counts as consumed.
  - In RUN with `mem_req`=1 and `mem_ack`=0: `pending_pc` ← `redirect_pc`, go to DRAIN.
  - In RUN with `mem_ack`=1 or `mem_req`=0: ack data is discarded, `fetch_pc` ← `redirect_pc`, stay in RUN.
  - In DRAIN with no ack: `pending_pc` ← newest `redirect_pc`, stay in DRAIN.
  - In DRAIN with ack: `fetch_pc` ← `redirect_pc`, go to RUN.
- At most one outstanding request. A request is only issued when a free slot exists, so a push never overflows.
- `mem_ack` while `mem_req`=0 is a protocol error and is ignored.

## Timing
- Reset (`rst`=0, async):
  - `count`=0, state RUN, `fetch_pc`=`RESET_PC`.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `mem_req`=0. `mem_req` is gated low while `rst`=0.
  - The first `mem_req`=1 appears in the first cycle with `rst`=1.
- Reset asserted mid-request drops `mem_req` immediately. The memory must abandon that request.
- `mem_req` and `mem_addr` are decoded from registered state only; there is no combinational path from `mem_ack`.
- `instr_valid` = (`count`≠0). `instr` and `instr_pc` come from the registered head entry.
- Latency: an ack in cycle N gives `instr_valid`=1 in N+1. With zero-wait memory (ack in the same cycle as req), throughput is one instruction per cycle.
- Full: when `count`=DEPTH, `mem_req`=0. It re-asserts in the cycle after the pop that frees a slot.
- Redirect in cycle N: `instr_valid`=0 in N+1. From RUN, the first new `mem_req` with `mem_addr`=`redirect_pc` appears in N+1.

## Structure
- Shared package `mips_pkg`:
  - `XLEN`=32.
  - `RESET_PC` default.
  - Fetch FSM enum {FETCH_RUN, FETCH_DRAIN}.
  - Typedef for the queue entry {pc, word}.
- One sub-module: `fetch_fifo`, a synchronous DEPTH-entry FIFO with push/pop/flush, `count`, and head outputs, with async active-low reset. The FSM and PC logic stay in `instr_fetch_buffer`.

## Test plan
- Reset and stream:
  - Stimulus: `RESET_PC`=0x0, zero-wait memory returning word = addr^0xA5A5_0000, `instr_ready`=1.
  - Required: `instr_pc` sequence 0x0, 0x4, 0x8 …, with `instr_valid` continuous from the 2nd cycle after reset release.
- Backpressure:
  - Stimulus: `instr_ready`=0 for 10 cycles.
  - Required: `count` reaches 4 and `mem_req`=0. After the first pop, `mem_req`=1 next cycle with `mem_addr`=0x10. No entry is lost or duplicated.
- Redirect with request in flight:
  - Stimulus: 3-cycle memory latency, `redirect`=1 with `redirect_pc`=0x100 one cycle after req to 0x8.
  - Required: `mem_addr` stays 0x8 until ack, then the next req goes to 0x100. The 0x8 data never appears, and the first valid `instr_pc` is 0x100.
- Same-cycle redirect and ack:
  - Stimulus: `redirect`=1 (`redirect_pc`=0x200) together with `mem_ack` for 0xC.
  - Required: no DRAIN; next cycle `mem_addr`=0x200 and `instr_valid`=0.
- Double redirect:
  - Stimulus: in DRAIN, redirects to 0x300 then 0x400 before the ack.
  - Required: fetch resumes at 0x400 only.
- Wrap and async reset:
  - Stimulus: `RESET_PC`=0xFFFF_FFF8.
  - Required: PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
  - Stimulus: async `rst`=0 mid-stream between clock edges.
  - Required: `instr_valid` and `mem_req` drop immediately.
